mem_arbiter_rr: RTL

//  Parametrised N-requester line-granularity memory arbiter between the L1 caches
//  (I$, D$, future prefetch or DMA ports) and the L2/cacheline-adaptor port.

---
 rtl/mem_arbiter_rr.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter_rr.sv
// Line-granularity arbiter: N L1 requesters share one L2/cacheline-adaptor port.
// Latched request reaches mem_* one cycle after grant; one dead cycle follows each completion.
module mem_arbiter_rr #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int RR_MODE = 1,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
    output logic [LINE_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]        req_resp,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [LINE_W-1:0]         mem_wdata,
    input  logic [LINE_W-1:0]         mem_rdata,
    input  logic                      mem_resp,
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt,
    output logic [NUM_REQ-1:0]        grant_ovf
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0] ovf_q, ovf_d;
    logic [NUM_REQ-1:0] pend;
    logic [IDX_W-1:0]   win;
    logic               win_vld;
    int                 win_i;

    assign pend = req_read | req_write;

    // Search starts at rr_ptr in round-robin mode, at index 0 otherwise.
    always_comb begin : pick
        int j;
        j       = 0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (RR_MODE != 0) ? (int'(rr_ptr_q) + k) % NUM_REQ : k;
            if (!win_vld && pend[j]) begin
                win     = IDX_W'(j);
                win_vld = 1'b1;
            end
        end
    end

    assign win_i = int'(win);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ovf_d       = ovf_q;
        req_resp    = '0;
        for (int i = 0; i < NUM_REQ; i++) cnt_d[i] = cnt_q[i];

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    idx_d       = win;
                    addr_d      = req_address[win_i*ADDR_W +: ADDR_W];
                    wdata_d     = req_wdata[win_i*LINE_W +: LINE_W];
                    mem_write_d = req_write[win];
                    mem_read_d  = !req_write[win];
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    req_resp[idx_q] = 1'b1;
                    mem_read_d      = 1'b0;
                    mem_write_d     = 1'b0;
                    state_d         = DONE;
                    rr_ptr_d        = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;
                    if (cnt_q[idx_q] != '1) cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
                    ovf_d[idx_q]    = ovf_q[idx_q] | (cnt_d[idx_q] == '1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rr_ptr_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ovf_q       <= '0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign req_rdata   = mem_rdata;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign grant_ovf   = ovf_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
endmodule
